// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Back-pressurable pipeline stage register with a 2-entry skid buffer.
// The head register H drives the outputs. The skid register S catches the
// entry that was accepted in the cycle the downstream stalled. Because of S,
// in_ready depends only on state and never on out_ready, and a one-cycle
// stall does not insert an upstream bubble.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   upstream has an entry
//   in_ready   stage can accept this cycle (low while reset is high)
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   flush      synchronous kill of all held entries (wins over handshake)
//   out_valid  head entry valid
//   out_ready  downstream consumes the head this cycle
//   out_ctrl   head control, forced to CTRL_BUBBLE when out_valid is low
//   out_data   head data (stale value when out_valid is low)
//   occupancy  number of entries held: 0, 1 or 2
module pipe_stage_skid #(
    parameter int                 CTRL_W      = 2,
    parameter int                 DATA_W      = 69,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
    parameter logic [DATA_W-1:0]  DATA_RESET  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              h_valid;
    logic [CTRL_W-1:0] h_ctrl;
    logic [DATA_W-1:0] h_data;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    logic acc;
    logic pop;

    // Only the skid state gates acceptance. The downstream ready is deliberately
    // absent, so there is no combinational ready path through this stage.
    assign in_ready = ~s_valid & ~reset;
    assign acc      = in_valid & in_ready;
    assign pop      = h_valid & out_ready;

    // Data registers are not cleared on pop or flush. Only the valid bits
    // change, which saves toggling on the wide data bundle.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_valid <= 1'b0;
            s_valid <= 1'b0;
            h_ctrl  <= CTRL_BUBBLE;
            s_ctrl  <= CTRL_BUBBLE;
            h_data  <= DATA_RESET;
            s_data  <= DATA_RESET;
        end else if (flush) begin
            h_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!h_valid) begin
            if (acc) begin
                h_valid <= 1'b1;
                h_ctrl  <= in_ctrl;
                h_data  <= in_data;
            end
        end else if (!s_valid) begin
            if (acc && pop) begin
                h_ctrl  <= in_ctrl;
                h_data  <= in_data;
            end else if (acc) begin
                s_valid <= 1'b1;
                s_ctrl  <= in_ctrl;
                s_data  <= in_data;
            end else if (pop) begin
                h_valid <= 1'b0;
            end
        end else if (pop) begin
            // Skid is full, so in_ready is low and nothing can be accepted.
            // Promote the skid entry to the head.
            h_ctrl  <= s_ctrl;
            h_data  <= s_data;
            s_valid <= 1'b0;
        end
    end

    assign out_valid = h_valid;
    // A bubble must never carry a live write enable downstream.
    assign out_ctrl  = h_valid ? h_ctrl : CTRL_BUBBLE;
    assign out_data  = h_data;
    assign occupancy = {1'b0, h_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    localparam int CW = 2;
    localparam int DW = 69;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model: a FIFO of capacity two plus the value last seen at the head.
    ent_t          q[$];
    logic [DW-1:0] stale_d;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_obs_acc = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic iv, input logic [CW-1:0] ic,
                        input logic [DW-1:0] id, input logic ordy, input logic fl);
        logic          exp_rdy, acc, pop, hv;
        logic [CW-1:0] hc;
        logic [DW-1:0] hd;
        @(negedge clk);
        reset = rst; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
        #1;
        hv = q.size() > 0;
        hc = '0;
        hd = stale_d;
        if (hv) begin
            hc = q[0].c;
            hd = q[0].d;
        end
        exp_rdy = !rst && (q.size() < 2);
        check_val("in_ready", 128'(in_ready), 128'(exp_rdy));
        check_val("out_valid", 128'(out_valid), 128'(hv));
        check_val("out_ctrl", 128'(out_ctrl), 128'(hc));
        check_val("out_data", 128'(out_data), 128'(hd));
        check_val("occupancy", 128'(occupancy), 128'(q.size()));
        check_val("skid_implies_head", 128'(!(dut.s_valid && !dut.h_valid)), 128'(1));
        if (in_ready && iv) n_obs_acc++;
        acc = iv && exp_rdy;
        pop = hv && ordy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            stale_d = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back({ic, id});
        end
        if (q.size() > 0) stale_d = q[0].d;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        stale_d = '0;
        repeat (2) @(posedge clk);

        // Reset held two cycles, then stream 1..4 with out_ready held high.
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, 2'(i), DW'(i), 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Single stall while 12 is at the head.
        for (int i = 10; i <= 15; i++) step(0, 1, 2'(i), DW'(i), (i != 13), 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);

        // Long stall: exactly two entries are accepted.
        base = n_obs_acc;
        for (int i = 0; i < 5; i++) step(0, 1, 2'(i), DW'(32 + i), 0, 0);
        check_val("long_stall_accepted", 128'(n_obs_acc - base), 128'(2));
        for (int i = 0; i < 4; i++) step(0, 1, 2'(i), DW'(48 + i), 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);

        // Flush while the skid is full, with 0xAA offered in the same cycle.
        step(0, 1, 1, 'h61, 0, 0);
        step(0, 1, 2, 'h62, 0, 0);
        step(0, 1, 3, 'hAA, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Bubble gating: ctrl 2'b11 accepted, then popped with no new input.
        step(0, 1, 2'b11, 'h77, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Reset mid-operation with the skid full.
        step(0, 1, 1, 'h81, 0, 0);
        step(0, 1, 2, 'h82, 0, 0);
        step(1, 1, 3, 'h83, 1, 0);
        step(1, 1, 3, 'h84, 1, 0);
        step(0, 1, 1, 'h85, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Randomised traffic in phases with different stall densities.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 600; i++) begin
                logic rst_r, fl_r, iv_r, or_r;
                rst_r = ($urandom_range(0, 199) == 0);
                fl_r  = ($urandom_range(0, 39) == 0);
                iv_r  = ($urandom_range(0, 3) != 0);
                or_r  = ($urandom_range(0, 3) >= ph);
                step(rst_r, iv_r, 2'($urandom), rnd_data(), or_r, fl_r);
            end
        end
        repeat (3) step(0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
